// File: rtl/conv_window_gen.sv
// Sliding KxK window generator over a padded feature map with stride S.
// Define CONV_WIN_IDX_EN to add the win_row/win_col window index outputs.
module conv_window_gen #(
  parameter int In_d_W = 32,
  parameter int R_N_P  = 7,
  parameter int C_N_P  = 7,
  parameter int K      = 3,
  parameter int S      = 1,
  localparam int OR    = (R_N_P - K) / S + 1,
  localparam int OC    = (C_N_P - K) / S + 1,
  localparam int RW    = (OR > 1) ? $clog2(OR) : 1,
  localparam int CW    = (OC > 1) ? $clog2(OC) : 1,
  localparam int MW    = R_N_P * C_N_P * In_d_W,
  localparam int WW    = K * K * In_d_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          start,
  input  logic [MW-1:0] N_P,
  input  logic          win_ready,
  output logic          win_valid,
  output logic [WW-1:0] win,
  output logic          busy,
`ifdef CONV_WIN_IDX_EN
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
`endif
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [RW-1:0] OR_M = RW'(OR - 1);
  localparam logic [CW-1:0] OC_M = CW'(OC - 1);

  state_t        r_state;
  logic [MW-1:0] r_snap;
  logic [WW-1:0] r_win;
  logic [RW-1:0] r_wr;
  logic [CW-1:0] r_wc;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;

  logic          w_xfer;
  logic          w_last_c;
  logic          w_last;
  logic [RW-1:0] w_nwr;
  logic [CW-1:0] w_nwc;

  function automatic logic [WW-1:0] f_win(
    input logic [MW-1:0] m,
    input int            wr,
    input int            wc
  );
    logic [WW-1:0] v;
    v = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        v[(i*K+j)*In_d_W +: In_d_W] =
          m[((wr*S+i)*C_N_P + wc*S+j)*In_d_W +: In_d_W];
      end
    end
    return v;
  endfunction

  assign w_xfer   = r_valid && win_ready;
  assign w_last_c = (r_wc == OC_M);
  assign w_last   = w_last_c && (r_wr == OR_M);

  // Column index runs fastest, wrapping into the next row.
  always_comb begin
    w_nwr = r_wr;
    w_nwc = r_wc + CW'(1);
    if (w_last_c) begin
      w_nwc = '0;
      w_nwr = r_wr + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_win   <= '0;
      r_wr    <= '0;
      r_wc    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (clr) begin
      r_state <= IDLE;
      r_wr    <= '0;
      r_wc    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_snap  <= N_P;
            r_win   <= f_win(N_P, 0, 0);
            r_wr    <= '0;
            r_wc    <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_wr    <= '0;
              r_wc    <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_wr  <= w_nwr;
              r_wc  <= w_nwc;
              r_win <= f_win(r_snap, int'(w_nwr), int'(w_nwc));
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign win_valid = r_valid;
  assign win       = r_win;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef CONV_WIN_IDX_EN
  assign win_row = r_wr;
  assign win_col = r_wc;
`endif

endmodule
